// File: rtl/synapse_seq_ctrl_pkg.sv
// Shared constants for the Synapse microsequencer: op codes, mux select
// encodings, config word header layout, FSM state codes and the per-op
// select lookup.
package synapse_seq_ctrl_pkg;

    // Config word op codes
    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_MAC   = 2'b01;
    localparam logic [1:0] OP_ACCF  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // Select encodings used by the op table.
    // m_mux1: 00 h_s_i, 01 h_s_o, 10 v_s_o, 11 v_b
    // m_mux2: 00 zero, 01 v_s_i, 10 h_s_i, 11 ram_o
    // a_mux1: 0 m_REG, 1 ram_o
    // a_mux2: 00 h_b_r, 01 h_b_l, 10 v_b_t, 11 v_b_b
    // h/v line: 00 hold-z, 01/10 bus side, 11 adder
    // ram_i: 00 zero, 01 h_REG, 10 v_REG, 11 a_out2
    localparam logic [1:0] M1_H_S_I    = 2'b00;
    localparam logic [1:0] M2_RAM_O    = 2'b11;
    localparam logic       A1_M_REG    = 1'b0;
    localparam logic [1:0] A2_H_B_L    = 2'b01;
    localparam logic [1:0] LINE_BUS_A  = 2'b01;
    localparam logic [1:0] LINE_ADDER  = 2'b11;
    localparam logic [1:0] RAMI_H_REG  = 2'b01;
    localparam logic [1:0] RAMI_A_OUT2 = 2'b11;

    // Header bits at the top of a config word: last flag plus 2-bit op
    localparam int CFG_HDR_W = 3;

    // FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Everything one op drives for the duration of a word; rd/we say whether
    // the op touches the DMEM read port and write port at all.
    typedef struct packed {
        logic [1:0] selMMux1;
        logic [1:0] selMMux2;
        logic       selAMux1;
        logic [1:0] selAMux2;
        logic       selA1;
        logic       selA2;
        logic [1:0] selHLine;
        logic [1:0] selVLine;
        logic [1:0] selRamI;
        logic       rd;
        logic       we;
    } selBundle_t;

    function automatic selBundle_t opSelects(input logic [1:0] op);
        selBundle_t s;
        s = '0;
        case (op)
            OP_PASS: begin
                s.selHLine = LINE_BUS_A;
                s.selVLine = LINE_BUS_A;
            end
            OP_MAC: begin
                s.selMMux1 = M1_H_S_I;
                s.selMMux2 = M2_RAM_O;
                s.selAMux1 = A1_M_REG;
                s.selAMux2 = A2_H_B_L;
                s.selA2    = 1'b1;
                s.selRamI  = RAMI_A_OUT2;
                s.rd       = 1'b1;
                s.we       = 1'b1;
            end
            OP_ACCF: begin
                s.selMMux1 = M1_H_S_I;
                s.selMMux2 = M2_RAM_O;
                s.selAMux1 = A1_M_REG;
                s.selAMux2 = A2_H_B_L;
                s.selA1    = 1'b1;
                s.selA2    = 1'b1;
                s.selHLine = LINE_ADDER;
                s.selRamI  = RAMI_A_OUT2;
                s.rd       = 1'b1;
            end
            OP_STORE: begin
                s.selRamI = RAMI_H_REG;
                s.we      = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/synapse_seq_ctrl_if.sv
// Scheduler / config memory / datapath side of one Synapse microsequencer.
// master is the array-level side, slave is the sequencer itself.
interface synapse_seq_ctrl_if #(
    parameter int AddrDMEM  = 8,
    parameter int AddrCMEM  = 4,
    parameter int ConfWidth = 32
);
    logic                 start;
    logic [AddrCMEM-1:0]  c_base;
    logic                 busy;
    logic                 done;
    logic [AddrCMEM-1:0]  c_addr;
    logic [ConfWidth-1:0] c_data;
    logic [AddrDMEM-1:0]  r_addr;
    logic [AddrDMEM-1:0]  w_addr;
    logic                 we_ram;
    logic [1:0]           sel_m_mux1;
    logic [1:0]           sel_m_mux2;
    logic                 sel_a_mux1;
    logic [1:0]           sel_a_mux2;
    logic                 sel_a1;
    logic                 sel_a2;
    logic [1:0]           sel_h_line;
    logic [1:0]           sel_v_line;
    logic [1:0]           sel_ram_i;

    modport master (
        output start, c_base, c_data,
        input  busy, done, c_addr, r_addr, w_addr, we_ram,
               sel_m_mux1, sel_m_mux2, sel_a_mux1, sel_a_mux2,
               sel_a1, sel_a2, sel_h_line, sel_v_line, sel_ram_i
    );

    modport slave (
        input  start, c_base, c_data,
        output busy, done, c_addr, r_addr, w_addr, we_ram,
               sel_m_mux1, sel_m_mux2, sel_a_mux1, sel_a_mux2,
               sel_a1, sel_a2, sel_h_line, sel_v_line, sel_ram_i
    );
endinterface

// File: rtl/synapse_seq_ctrl_wb_delay.sv
// Write-back delay line: carries {we, w_addr} from the read-issue cycle to
// the cycle the multiplier result is ready. Reset empties it so queued
// writes are dropped.
module syn_wb_delay #(
    parameter int Width = 9,
    parameter int Depth = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] line_q [Depth];

    // Shift one stage per clock, stage 0 takes the new entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= d_i;
            for (int i = 1; i < Depth; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign q_o = line_q[Depth-1];
endmodule

// File: rtl/synapse_seq_ctrl.sv
// Microsequencer for one Synapse cell: walks config words from c_base,
// sweeps DMEM read addresses per word and issues delayed write-backs.
module synapse_seq_ctrl
    import synapse_seq_ctrl_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int AddrDMEM  = 8,
    parameter int AddrCMEM  = 4,
    parameter int ConfWidth = 32,
    parameter int WB_LAT    = 1
) (
    input logic               clk,
    input logic               rst,
    synapse_seq_ctrl_if.slave bus
);
    localparam int LenMsb   = ConfWidth - 1 - CFG_HDR_W;
    localparam int RBaseMsb = LenMsb - AddrDMEM;
    localparam int WBaseMsb = RBaseMsb - AddrDMEM;
    localparam int DrainW   = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;

    if (ConfWidth < CFG_HDR_W + 3 * AddrDMEM || WB_LAT < 1 || DataWidth < 1) begin : gBadParams
        $error("synapse_seq_ctrl: config word too narrow or WB_LAT < 1");
    end

    logic [2:0]          state_q, state_d;
    logic [AddrCMEM-1:0] cAddr_q;
    logic                last_q;
    logic [1:0]          op_q;
    logic [AddrDMEM-1:0] len_q, rBase_q, wBase_q, idx_q;
    logic [DrainW-1:0]   drainCnt_q;

    logic                cfgLast;
    logic [1:0]          cfgOp;
    logic [AddrDMEM-1:0] cfgLen, cfgRBase, cfgWBase;
    logic                unusedCData;
    logic                lastElem, drainEnd, inRun;
    selBundle_t          sel;
    logic [AddrDMEM:0]   wbIn, wbOut;

    assign cfgLast     = bus.c_data[ConfWidth-1];
    assign cfgOp       = bus.c_data[ConfWidth-2 -: 2];
    assign cfgLen      = bus.c_data[LenMsb -: AddrDMEM];
    assign cfgRBase    = bus.c_data[RBaseMsb -: AddrDMEM];
    assign cfgWBase    = bus.c_data[WBaseMsb -: AddrDMEM];
    assign unusedCData = ^bus.c_data;

    assign lastElem = (idx_q == len_q - AddrDMEM'(1));
    assign drainEnd = (drainCnt_q == DrainW'(WB_LAT - 1));
    assign inRun    = (state_q == ST_RUN);

    // Next-state: an empty word behaves as if its drain had just finished
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (cfgLen != '0)  state_d = ST_RUN;
                else if (cfgLast)  state_d = ST_DONE;
                else               state_d = ST_FETCH;
            end
            ST_RUN:   if (lastElem) state_d = ST_DRAIN;
            ST_DRAIN: if (drainEnd) state_d = last_q ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, config word latch and element/drain counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cAddr_q    <= '0;
            last_q     <= 1'b0;
            op_q       <= '0;
            len_q      <= '0;
            rBase_q    <= '0;
            wBase_q    <= '0;
            idx_q      <= '0;
            drainCnt_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (bus.start) cAddr_q <= bus.c_base;
                ST_FETCH: begin
                    last_q     <= cfgLast;
                    op_q       <= cfgOp;
                    len_q      <= cfgLen;
                    rBase_q    <= cfgRBase;
                    wBase_q    <= cfgWBase;
                    cAddr_q    <= cAddr_q + AddrCMEM'(1);
                    idx_q      <= '0;
                    drainCnt_q <= '0;
                end
                ST_RUN:   idx_q      <= idx_q + AddrDMEM'(1);
                ST_DRAIN: drainCnt_q <= drainCnt_q + DrainW'(1);
                default:  ;
            endcase
        end
    end

    // Selects are live for the whole word including the drain, zero otherwise
    always_comb begin
        sel = '0;
        if (state_q == ST_RUN || state_q == ST_DRAIN) sel = opSelects(op_q);
    end

    // Write request enters the delay line in the same cycle its read issues
    always_comb begin
        wbIn = '0;
        if (inRun && sel.we) wbIn = {1'b1, wBase_q + idx_q};
    end

    syn_wb_delay #(
        .Width (AddrDMEM + 1),
        .Depth (WB_LAT)
    ) uWbDelay (
        .clk (clk),
        .rst (rst),
        .d_i (wbIn),
        .q_o (wbOut)
    );

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.c_addr     = cAddr_q;
    assign bus.r_addr     = (inRun && sel.rd) ? rBase_q + idx_q : '0;
    assign bus.we_ram     = wbOut[AddrDMEM];
    assign bus.w_addr     = wbOut[AddrDMEM-1:0];
    assign bus.sel_m_mux1 = sel.selMMux1;
    assign bus.sel_m_mux2 = sel.selMMux2;
    assign bus.sel_a_mux1 = sel.selAMux1;
    assign bus.sel_a_mux2 = sel.selAMux2;
    assign bus.sel_a1     = sel.selA1;
    assign bus.sel_a2     = sel.selA2;
    assign bus.sel_h_line = sel.selHLine;
    assign bus.sel_v_line = sel.selVLine;
    assign bus.sel_ram_i  = sel.selRamI;
endmodule

// File: tb/tb_synapse_seq_ctrl.sv
// Directed bench for synapse_seq_ctrl with default parameters (WB_LAT=1).
// Each program run records every output once per cycle (cycle 0 is the
// cycle start is presented) and the recorded trace is compared against
// hand-derived timelines.
module tb_synapse_seq_ctrl;
    import synapse_seq_ctrl_pkg::*;

    logic clk;
    logic rst;

    synapse_seq_ctrl_if bus ();

    synapse_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] cmem [16];
    assign bus.c_data = cmem[bus.c_addr];

    logic [63:0] allOut;
    assign allOut = {26'd0, bus.r_addr, bus.w_addr, bus.we_ram, bus.busy, bus.done,
                     bus.c_addr, bus.sel_m_mux1, bus.sel_m_mux2, bus.sel_a_mux1,
                     bus.sel_a_mux2, bus.sel_a1, bus.sel_a2, bus.sel_h_line,
                     bus.sel_v_line, bus.sel_ram_i};

    int checks   = 0;
    int failures = 0;

    logic [63:0] obsAll  [32];
    logic [7:0]  obsR    [32];
    logic [7:0]  obsW    [32];
    logic        obsWe   [32];
    logic        obsDone [32];
    logic        obsBusy [32];
    logic        obsA1   [32];
    logic        obsA2   [32];
    logic [3:0]  obsC    [32];
    logic [1:0]  obsHl   [32];
    logic [1:0]  obsVl   [32];
    logic [1:0]  obsRamI [32];
    logic [1:0]  obsM2   [32];
    logic [1:0]  obsAm2  [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mkWord(input logic last, input logic [1:0] op,
                                           input logic [7:0] len, input logic [7:0] rb,
                                           input logic [7:0] wb);
        return {last, op, len, rb, wb, 5'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a program at base and record cycles; pulseMask[k] re-asserts start
    // during cycle k (k>=1); reset is raised after sampling cycle resetAt.
    task automatic applyStimulus(input logic [3:0] base, input int cycles,
                                 input logic [31:0] pulseMask, input int resetAt);
        bus.c_base = base;
        bus.start  = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            obsAll[k]  = allOut;
            obsR[k]    = bus.r_addr;
            obsW[k]    = bus.w_addr;
            obsWe[k]   = bus.we_ram;
            obsDone[k] = bus.done;
            obsBusy[k] = bus.busy;
            obsA1[k]   = bus.sel_a1;
            obsA2[k]   = bus.sel_a2;
            obsC[k]    = bus.c_addr;
            obsHl[k]   = bus.sel_h_line;
            obsVl[k]   = bus.sel_v_line;
            obsRamI[k] = bus.sel_ram_i;
            obsM2[k]   = bus.sel_m_mux2;
            obsAm2[k]  = bus.sel_a_mux2;
            if (k == resetAt) rst = 1'b1;
            else if (k == resetAt + 1) rst = 1'b0;
            tick();
            bus.c_base = ~base;
            bus.start  = (k + 1 < 32) ? pulseMask[k+1] : 1'b0;
        end
        bus.start = 1'b0;
        repeat (2) tick();
    endtask

    // MAC len=4 timeline: FETCH k1, RUN k2..k5, DRAIN k6, DONE k7
    task automatic checkMacRun(input string tag, input logic [7:0] rb, input logic [7:0] wb);
        logic [7:0] e;
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("%s we[%0d]", tag, k), 64'(obsWe[k]), 64'(k >= 3 && k <= 6));
            checkOutput($sformatf("%s done[%0d]", tag, k), 64'(obsDone[k]), 64'(k == 7));
            checkOutput($sformatf("%s busy[%0d]", tag, k), 64'(obsBusy[k]), 64'(k >= 1 && k <= 7));
            if (k >= 2 && k <= 5) begin
                e = rb + 8'(k - 2);
                checkOutput($sformatf("%s r_addr[%0d]", tag, k), 64'(obsR[k]), 64'(e));
            end
            if (k >= 3 && k <= 6) begin
                e = wb + 8'(k - 3);
                checkOutput($sformatf("%s w_addr[%0d]", tag, k), 64'(obsW[k]), 64'(e));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) cmem[i] = 32'd0;
        cmem[0]  = mkWord(1'b1, OP_MAC,   8'd4, 8'h10, 8'h20);
        cmem[2]  = mkWord(1'b1, OP_MAC,   8'd8, 8'h70, 8'h80);
        cmem[4]  = mkWord(1'b1, OP_MAC,   8'd4, 8'hFE, 8'hFF);
        cmem[6]  = mkWord(1'b1, OP_ACCF,  8'd1, 8'h55, 8'h66);
        cmem[8]  = mkWord(1'b0, OP_MAC,   8'd0, 8'h11, 8'h22);
        cmem[9]  = mkWord(1'b1, OP_STORE, 8'd2, 8'h30, 8'h40);
        cmem[12] = mkWord(1'b0, OP_PASS,  8'd2, 8'h00, 8'h00);
        cmem[13] = mkWord(1'b1, OP_PASS,  8'd1, 8'h00, 8'h00);
        cmem[14] = mkWord(1'b1, OP_PASS,  8'd3, 8'h50, 8'h60);

        // Reset state
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.c_base = 4'd0;
        #1;
        checkOutput("reset all outputs", allOut, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        checkOutput("idle after reset", allOut, 64'd0);

        // Single MAC word
        applyStimulus(4'd0, 10, 32'd0, -1);
        checkMacRun("mac", 8'h10, 8'h20);
        checkOutput("mac fetch ram_i", 64'(obsRamI[1]), 64'd0);
        checkOutput("mac run m2", 64'(obsM2[2]), 64'(2'b11));
        checkOutput("mac run a_mux2", 64'(obsAm2[2]), 64'(2'b01));
        checkOutput("mac run a2", 64'(obsA2[2]), 64'd1);
        checkOutput("mac run a1", 64'(obsA1[2]), 64'd0);
        checkOutput("mac drain ram_i", 64'(obsRamI[6]), 64'(2'b11));
        checkOutput("mac done ram_i", 64'(obsRamI[7]), 64'd0);
        checkOutput("mac c_addr after", 64'(obsC[7]), 64'd1);

        // DMEM address wrap
        applyStimulus(4'd4, 10, 32'd0, -1);
        checkMacRun("wrap", 8'hFE, 8'hFF);

        // ACCF forwards sums, never writes
        applyStimulus(4'd6, 6, 32'd0, -1);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("accf we[%0d]", k), 64'(obsWe[k]), 64'd0);
        checkOutput("accf r_addr", 64'(obsR[2]), 64'h55);
        checkOutput("accf h_line run", 64'(obsHl[2]), 64'(2'b11));
        checkOutput("accf h_line drain", 64'(obsHl[3]), 64'(2'b11));
        checkOutput("accf a1", 64'(obsA1[2]), 64'd1);
        checkOutput("accf done", 64'(obsDone[4]), 64'd1);

        // Empty word followed by STORE len=2
        applyStimulus(4'd8, 9, 32'd0, -1);
        checkOutput("len0 c_addr", 64'(obsC[2]), 64'd9);
        for (int k = 0; k < 9; k++) begin
            checkOutput($sformatf("store we[%0d]", k), 64'(obsWe[k]), 64'(k == 4 || k == 5));
            checkOutput($sformatf("store done[%0d]", k), 64'(obsDone[k]), 64'(k == 6));
            if (k >= 1 && k <= 6)
                checkOutput($sformatf("store ram_i[%0d]", k), 64'(obsRamI[k]),
                            64'((k >= 3 && k <= 5) ? 2'b01 : 2'b00));
        end
        checkOutput("store w_addr0", 64'(obsW[4]), 64'h40);
        checkOutput("store w_addr1", 64'(obsW[5]), 64'h41);

        // start re-pulsed while busy (k3) and during DONE (k8) is ignored
        applyStimulus(4'd12, 12, 32'h0000_0108, -1);
        checkOutput("repulse c_addr fetch2", 64'(obsC[5]), 64'd13);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("repulse done[%0d]", k), 64'(obsDone[k]), 64'(k == 8));
            checkOutput($sformatf("repulse busy[%0d]", k), 64'(obsBusy[k]), 64'(k >= 1 && k <= 8));
        end

        // PASS len=3
        applyStimulus(4'd14, 8, 32'd0, -1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("pass h_line[%0d]", k), 64'(obsHl[k]),
                        64'((k >= 2 && k <= 5) ? 2'b01 : 2'b00));
            checkOutput($sformatf("pass v_line[%0d]", k), 64'(obsVl[k]),
                        64'((k >= 2 && k <= 5) ? 2'b01 : 2'b00));
            checkOutput($sformatf("pass we[%0d]", k), 64'(obsWe[k]), 64'd0);
        end

        // Reset in the middle of a MAC len=8 at element 3
        applyStimulus(4'd2, 14, 32'd0, 5);
        checkOutput("midrst r_addr i3", 64'(obsR[5]), 64'h73);
        checkOutput("midrst we before", 64'(obsWe[5]), 64'd1);
        checkOutput("midrst all outputs", obsAll[6], 64'd0);
        for (int k = 7; k < 14; k++) begin
            checkOutput($sformatf("midrst we[%0d]", k), 64'(obsWe[k]), 64'd0);
            checkOutput($sformatf("midrst busy[%0d]", k), 64'(obsBusy[k]), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
